// File: rtl/redirect_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the hazard-side redirect sequencer of the 2-stage
// fetch/execute pipeline.
//   WORD_W          : width of an instruction/data word (32)
//   word_t          : one machine word, same shape as the core's word type
//   hazard_state_t  : redirect sequencer states
//                     HZ_IDLE          - no redirect pending
//                     HZ_REDIRECT_WAIT - redirect parked until imem finishes
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    HZ_IDLE,
    HZ_REDIRECT_WAIT
  } hazard_state_t;

endpackage

// File: rtl/redirect_hazard_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one per enabled cycle and sticks at
// all-ones instead of wrapping.
// Parameters:
//   W        counter width (>= 1)
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset, clears the count
//   i_inc    in   1   count this cycle
//   o_count  out  W   current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Once every bit is set the counter parks there so a long run never
  // reads back as a small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/redirect_hazard_unit.sv
// ---------------------------------------------------------------------------
// redirect_hazard_unit
// Hazard-side end of the execute<->hazard link. Turns execute's dmem wait
// and branch mispredict into stall/flush controls, sequences the fetch PC
// redirect (parking it while an imem fetch is still in flight), tracks
// whether the fetch->execute latch holds a real instruction, and keeps two
// saturating performance counters.
// Parameters:
//   CNT_W              width of the perf counters (>= 1)
// Ports:
//   CLK                in   1      rising-edge clock
//   nRST               in   1      asynchronous active-low reset
//   dwait              in   1      execute: dmem access outstanding
//   branch_mispredict  in   1      execute: resolved path differs from fetch
//   branch_jump_addr   in   32     execute: correct target
//   iwait              in   1      fetch: imem access outstanding
//   ex_stall           out  1      execute: hold current instruction
//   ex_flush           out  1      execute: latch holds a bubble
//   fe_stall           out  1      fetch: hold PC and fetch->execute latch
//   fe_flush           out  1      fetch: load bubble into the latch
//   pc_load            out  1      fetch: load PC from pc_load_addr
//   pc_load_addr       out  32     redirect target (0 when pc_load=0)
//   redirect_busy      out  1      redirect parked behind in-flight fetch
//   stall_cycles       out  CNT_W  cycles with dwait=1, saturating
//   flush_events       out  CNT_W  accepted mispredicts, saturating
// ---------------------------------------------------------------------------
module redirect_hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dwait,
  input  logic              branch_mispredict,
  input  logic [WORD_W-1:0] branch_jump_addr,
  input  logic              iwait,
  output logic              ex_stall,
  output logic              ex_flush,
  output logic              fe_stall,
  output logic              fe_flush,
  output logic              pc_load,
  output logic [WORD_W-1:0] pc_load_addr,
  output logic              redirect_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  hazard_state_t     r_state;
  hazard_state_t     w_nextState;
  logic [WORD_W-1:0] r_redirect;
  logic              r_valid;

  logic              w_accept;
  logic              w_feFlush;
  logic              w_pcLoad;
  logic [WORD_W-1:0] w_pcLoadAddr;
  logic              w_captureRedirect;
  logic              w_busy;

  // A mispredict seen while dmem is busy is left alone; execute is stalled
  // and keeps presenting it until dwait drops.
  assign w_accept = branch_mispredict & ~dwait;

  // Redirect sequencing. In IDLE a redirect either fires immediately or,
  // when imem is mid-fetch, is parked so the stale fetch can complete first.
  // While parked every fetched word is discarded.
  always_comb begin
    w_nextState       = r_state;
    w_feFlush         = 1'b0;
    w_pcLoad          = 1'b0;
    w_pcLoadAddr      = '0;
    w_captureRedirect = 1'b0;
    w_busy            = 1'b0;
    case (r_state)
      HZ_IDLE: begin
        if (w_accept) begin
          w_feFlush = 1'b1;
          if (!iwait) begin
            w_pcLoad     = 1'b1;
            w_pcLoadAddr = branch_jump_addr;
          end else begin
            w_captureRedirect = 1'b1;
            w_nextState       = HZ_REDIRECT_WAIT;
          end
        end else if (!dwait && iwait) begin
          w_feFlush = 1'b1;
        end
      end
      HZ_REDIRECT_WAIT: begin
        w_busy    = 1'b1;
        w_feFlush = 1'b1;
        if (!iwait) begin
          w_pcLoad     = 1'b1;
          w_pcLoadAddr = r_redirect;
          w_nextState  = HZ_IDLE;
        end
      end
      default: begin
        w_nextState = HZ_IDLE;
      end
    endcase
  end

  // State and parked target. Reset drops any pending redirect; fetch then
  // restarts from its own reset PC.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= HZ_IDLE;
      r_redirect <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_captureRedirect) begin
        r_redirect <= branch_jump_addr;
      end
    end
  end

  // Validity of the fetch->execute latch. A flush always wins over a stall,
  // so a parked redirect keeps bubbling the latch even under dwait.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
    end else if (dwait && !w_feFlush) begin
      r_valid <= r_valid;
    end else begin
      r_valid <= ~w_feFlush;
    end
  end

  assign ex_stall      = dwait;
  assign fe_stall      = dwait;
  assign ex_flush      = ~r_valid;
  assign fe_flush      = w_feFlush;
  assign pc_load       = w_pcLoad;
  assign pc_load_addr  = w_pcLoadAddr;
  assign redirect_busy = w_busy;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_inc   (dwait),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_inc   (w_accept),
    .o_count (flush_events)
  );

  // The cycle after a redirect execute sees a bubble, so it cannot
  // legitimately report another mispredict.
  a_noBackToBack : assert property (
    @(posedge CLK) disable iff (!nRST) pc_load |=> !branch_mispredict
  );

endmodule
